dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory (`dataMem`) between the processor core's load/store path (requester 0) and a DMA/program-loader port (requester 1). It sits between the requesters and `dataMem`. It grants one access per cycle with round-robin fairness and a bounded burst hold. For accepted reads it returns registered read data one cycle later. It lets a loader fill or inspect data memory while the core is running, without corrupting core accesses.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arbiter_rr_pick2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core
// load/store path and the DMA/loader port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;

    function automatic arb_state_t own_state(input logic who);
        return who ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational winner select for two requesters: round-robin on ties from
// idle, owner keeps the memory until its burst limit is reached.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  req_i,
    input  arb_state_t  state_i,
    input  logic        last_i,
    input  logic        burst_max_i,
    output logic        win_valid_o,
    output logic        win_o
);

    // Winner decode from the request pair and current ownership
    always_comb begin
        win_valid_o = 1'b0;
        win_o       = REQ_CPU;
        case (req_i)
            2'b01: begin
                win_valid_o = 1'b1;
                win_o       = REQ_CPU;
            end
            2'b10: begin
                win_valid_o = 1'b1;
                win_o       = REQ_DMA;
            end
            2'b11: begin
                win_valid_o = 1'b1;
                case (state_i)
                    OWN0:    win_o = burst_max_i ? REQ_DMA : REQ_CPU;
                    OWN1:    win_o = burst_max_i ? REQ_CPU : REQ_DMA;
                    IDLE:    win_o = ~last_i;
                    default: win_o = ~last_i;
                endcase
            end
            default: begin
                win_valid_o = 1'b0;
                win_o       = REQ_CPU;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dataMem between the core (requester 0) and a DMA/loader
// (requester 1); one access per cycle, registered read return one cycle later.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;
    logic [3:0]        burst_q, burst_d;
    logic              r0_rvalid_q, r1_rvalid_q;
    logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;

    logic              win_valid_s;
    logic              win_s;
    logic              rd0_s, rd1_s;

    rr_pick2 u_pick (
        .req_i       ({r1_req, r0_req}),
        .state_i     (state_q),
        .last_i      (last_q),
        .burst_max_i (burst_q == BURST_LIM),
        .win_valid_o (win_valid_s),
        .win_o       (win_s)
    );

    // Grants are forced low during reset so no write can slip through
    assign r0_gnt    = reset_n & win_valid_s & (win_s == REQ_CPU);
    assign r1_gnt    = reset_n & win_valid_s & (win_s == REQ_DMA);
    assign mem_we    = (r0_gnt & r0_we) | (r1_gnt & r1_we);
    assign mem_addr  = r1_gnt ? r1_addr  : r0_addr;
    assign mem_wdata = r1_gnt ? r1_wdata : r0_wdata;
    assign rd0_s     = r0_gnt & ~r0_we;
    assign rd1_s     = r1_gnt & ~r1_we;

    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;

    // Ownership, last-served and burst-length next state
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        burst_d = 4'd0;
        if (win_valid_s) begin
            state_d = own_state(win_s);
            last_d  = win_s;
            if (state_q == own_state(win_s)) begin
                burst_d = (burst_q == BURST_LIM) ? BURST_LIM : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end else begin
            state_d = IDLE;
            last_d  = last_q;
            burst_d = 4'd0;
        end
    end

    // State registers and read-return pipeline; last resets to 1 so requester 0 wins first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_q     <= 4'd0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_q     <= burst_d;
            r0_rvalid_q <= rd0_s;
            r1_rvalid_q <= rd1_s;
            if (rd0_s) begin
                r0_rdata_q <= mem_rdata;
            end else begin
                r0_rdata_q <= r0_rdata_q;
            end
            if (rd1_s) begin
                r1_rdata_q <= mem_rdata;
            end else begin
                r1_rdata_q <= r1_rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

    localparam int MAX_B = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic        init_mem;

    logic [31:0] ref_mem [0:255];
    int          own_m, run_m, last_m;
    logic        pend0, pend1;
    logic [31:0] pd0, pd1;
    int          wait0, wait1;
    logic        g0_last;
    int          errors = 0;
    int          checks = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_B)) dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Behavioural dataMem: combinational read, write on rising edge
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic q0, input logic q1);
        if (!q0 && !q1) return -1;
        if (q0 && !q1) return 0;
        if (q1 && !q0) return 1;
        if (own_m < 0) return 1 - last_m;
        if (run_m < MAX_B) return own_m;
        return 1 - own_m;
    endfunction

    task automatic model_reset();
        own_m = -1; run_m = 0; last_m = 1;
        pend0 = 1'b0; pend1 = 1'b0; wait0 = 0; wait1 = 0;
    endtask

    task automatic step(input logic q0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                        input logic q1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        int w;
        r0_req = q0; r0_we = w0; r0_addr = {22'd0, a0, 2'b00}; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = {22'd0, a1, 2'b00}; r1_wdata = d1;
        @(negedge clk);
        w = pick(q0, q1);
        g0_last = r0_gnt;
        chk("gnt0", r0_gnt, w == 0);
        chk("gnt1", r1_gnt, w == 1);
        chk("mem_we", mem_we, (w == 0) ? w0 : (w == 1) ? w1 : 1'b0);
        chk("mem_addr", mem_addr, (w == 1) ? r1_addr : r0_addr);
        if (w >= 0) chk("mem_wdata", mem_wdata, (w == 1) ? d1 : d0);
        chk("rvalid0", r0_rvalid, pend0);
        chk("rvalid1", r1_rvalid, pend1);
        if (pend0) chk("rdata0", r0_rdata, pd0);
        if (pend1) chk("rdata1", r1_rdata, pd1);
        wait0 = (q0 && w != 0) ? wait0 + 1 : 0;
        wait1 = (q1 && w != 1) ? wait1 + 1 : 0;
        chk("starve0", wait0 <= MAX_B, 1'b1);
        chk("starve1", wait1 <= MAX_B, 1'b1);
        @(posedge clk);
        pend0 = (w == 0) && !w0;
        pend1 = (w == 1) && !w1;
        if (pend0) pd0 = ref_mem[a0];
        if (pend1) pd1 = ref_mem[a1];
        if (w == 0 && w0) ref_mem[a0] = d0;
        if (w == 1 && w1) ref_mem[a1] = d1;
        if (w < 0) begin
            own_m = -1; run_m = 0;
        end else begin
            run_m = (w == own_m) ? ((run_m < MAX_B) ? run_m + 1 : MAX_B) : 1;
            own_m = w; last_m = w;
        end
        #1;
    endtask

    task automatic rst_step(input logic q0, input logic w0, input logic [7:0] a0,
                            input logic q1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        r0_req = q0; r0_we = w0; r0_addr = {22'd0, a0, 2'b00}; r0_wdata = 32'd0;
        r1_req = q1; r1_we = w1; r1_addr = {22'd0, a1, 2'b00}; r1_wdata = d1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_gnt0", r0_gnt, 1'b0);
        chk("rst_gnt1", r1_gnt, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rvalid0", r0_rvalid, 1'b0);
        chk("rst_rvalid1", r1_rvalid, 1'b0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [9:0] seq;
        int         gsum;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        model_reset();
        init_mem = 1'b1;
        reset_n  = 1'b0;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd0; r0_wdata = 32'd0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'd0; r1_wdata = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        rst_step(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 32'd0);

        // Tie from reset: requester 0 first, read data one cycle later
        step(1'b1, 1'b0, 8'h04, 32'd0, 1'b1, 1'b0, 8'h08, 32'd0);
        chk("first_tie_r0", g0_last, 1'b1);
        chk("t1_rvalid0", r0_rvalid, 1'b1);
        chk("t1_rdata0", r0_rdata, pat(4));
        step(1'b0, 1'b0, 8'h04, 32'd0, 1'b1, 1'b0, 8'h08, 32'd0);
        chk("t1_rdata1", r1_rdata, pat(8));

        // Burst limit pattern from idle
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(i), 32'd0, 1'b1, 1'b0, 8'(i + 16), 32'd0);
            seq[i] = g0_last;
        end
        chk("burst_pattern", seq, 10'b1100001111);

        // Lone writer streams with no yield
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 8'h10 + 8'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) chk("burst_wr_mem", mem[8'h10 + 8'(i)], 32'hA0 + 32'(i));

        // Write then read from the other requester sees new data
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
        step(1'b1, 1'b0, 8'h20, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        chk("raw_rdata0", r0_rdata, 32'hDEADBEEF);

        // Reset during a granted read and a granted write
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        rst_step(1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 8'h00, 32'd0);
        rst_step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 32'h12345678);
        chk("rst_mem_kept", mem[6], pat(6));
        step(1'b1, 1'b0, 8'h06, 32'd0, 1'b1, 1'b0, 8'h07, 32'd0);
        chk("post_rst_tie_r0", g0_last, 1'b1);
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 8'h07, 32'd0);

        // Requester 0 blips while requester 1 streams
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        gsum = 0;
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 8'h30, 32'h55);
        gsum += int'(g0_last);
        step(1'b1, 1'b0, 8'h30, 32'd0, 1'b1, 1'b1, 8'h31, 32'h56);
        gsum += int'(g0_last);
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b1, 8'h32, 32'h57);
        gsum += int'(g0_last);
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b1, 1'b0, 8'h30, 32'd0);
        gsum += int'(g0_last);
        chk("blip_no_gnt0", gsum, 0);
        chk("blip_no_rvalid0", r0_rvalid, 1'b0);
        chk("blip_stream_rd", r1_rdata, 32'h55);

        // Random traffic on a small address window
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)), $urandom);
        end
        step(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0, 8'h00, 32'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
